keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad, debounces it, and delivers one key-press event per physical press over a valid/ready handshake.
- It is the input-side counterpart of the multiplexed 7-segment driver: it drives rows one-hot active-low in rotation and reads the columns back.
- Sits between board keypad pins and the game control logic.

---
 rtl/keypad_pkg.sv | 8 +
 rtl/keypad_frame_scan.sv | 70 +++++++
 rtl/keypad_scanner.sv | 120 ++++++++++++
 tb/tb_keypad_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} result_t;
endpackage

// File: rtl/keypad_frame_scan.sv
// Row rotation, column synchronizer, per-slot sampling and end-of-frame
// classification of the 16 key positions.
module keypad_frame_scan
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES = 3
) (
    input  logic          clk_1000HZ,
    input  logic          reset,
    input  logic [3:0]    col,
    output logic [3:0]    row,
    output logic          frame_done,
    output result_t       result,
    output logic [3:0]    code
);
    localparam int SW = $clog2(ROW_CYCLES);

    logic [SW-1:0]                        slot_cnt;
    logic [1:0]                           row_idx;
    logic [NUM_COLS-1:0]                  col_m, col_s;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]    cols_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0]    frame_v;
    logic [4:0]                           zeros;
    logic                                 slot_end;

    assign slot_end   = (slot_cnt == SW'(ROW_CYCLES - 1));
    assign frame_done = slot_end && (row_idx == 2'd3);

    always_ff @(posedge clk_1000HZ) begin
        if (reset) begin
            row      <= 4'b1110;
            row_idx  <= '0;
            slot_cnt <= '0;
            col_m    <= '0;
            col_s    <= '0;
            cols_q   <= '1;
        end else begin
            col_m <= col;
            col_s <= col_m;
            if (slot_end) begin
                slot_cnt        <= '0;
                row             <= {row[2:0], row[3]};
                row_idx         <= row_idx + 2'd1;
                cols_q[row_idx] <= col_s;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

    // The row being captured this cycle is taken straight from col_s so the
    // classification is ready on the frame's final cycle.
    always_comb begin
        frame_v = cols_q;
        frame_v[row_idx] = col_s;
        zeros = '0;
        code  = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (!frame_v[r][c]) begin
                    zeros = zeros + 5'd1;
                    code  = 4'(r * NUM_COLS + c);
                end
            end
        end
        if (zeros == 5'd0)      result = NONE;
        else if (zeros == 5'd1) result = SINGLE;
        else                    result = MULTI;
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: debounce FSM and valid/ready key event delivery
// on top of the frame scanner.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_CYCLES     = 3,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_1000HZ,
    input  logic        reset,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ready,
    output logic        key_held,
    output logic        key_overrun
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic          frame_done;
    result_t       result;
    logic [3:0]    code;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, rel, rel_n;
    logic [3:0]    cand, cand_n;
    logic          emit;

    keypad_frame_scan #(.ROW_CYCLES(ROW_CYCLES)) u_scan (
        .clk_1000HZ (clk_1000HZ),
        .reset      (reset),
        .col        (col),
        .row        (row),
        .frame_done (frame_done),
        .result     (result),
        .code       (code)
    );

    assign key_held = (state == HELD);

    always_ff @(posedge clk_1000HZ) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rel         <= '0;
            cand        <= '0;
            key_valid   <= 1'b0;
            key_code    <= '0;
            key_overrun <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            rel         <= rel_n;
            cand        <= cand_n;
            // An event arriving while one is still pending is dropped.
            key_overrun <= emit && key_valid;
            if (emit && !key_valid) begin
                key_valid <= 1'b1;
                key_code  <= cand_n;
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rel_n   = rel;
        cand_n  = cand;
        emit    = 1'b0;
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (result == SINGLE) begin
                        cand_n = code;
                        if (DEBOUNCE_SCANS == 1) begin
                            emit    = 1'b1;
                            state_n = HELD;
                            rel_n   = '0;
                            cnt_n   = '0;
                        end else begin
                            state_n = DEBOUNCE;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (result == SINGLE && code == cand) begin
                        if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                            emit    = 1'b1;
                            state_n = HELD;
                            rel_n   = '0;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                HELD: begin
                    if (result == NONE) begin
                        if (rel == CW'(DEBOUNCE_SCANS - 1)) begin
                            state_n = IDLE;
                            rel_n   = '0;
                        end else begin
                            rel_n = rel + CW'(1);
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model.
module tb_keypad_scanner;
    logic        clk_1000HZ = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  col, row, key_code;
    logic        key_valid, key_held, key_overrun;
    logic        key_ready = 1'b1;
    logic [15:0] pressed = '0;
    int          cyc = 0;
    int          n_events = 0;
    int          n_overrun = 0;
    int          passes = 0;
    int          total = 0;
    logic [3:0]  last_code = '0;

    always #5 clk_1000HZ = ~clk_1000HZ;

    // Pressed key at (r,c) pulls col[c] low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            if (row[r] == 1'b0)
                for (int c = 0; c < 4; c++)
                    if (pressed[r*4+c]) col[c] = 1'b0;
    end

    keypad_scanner dut (
        .clk_1000HZ  (clk_1000HZ),
        .reset       (reset),
        .col         (col),
        .row         (row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_held    (key_held),
        .key_overrun (key_overrun)
    );

    always @(posedge clk_1000HZ) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
        if (!reset && key_valid && key_ready) begin
            n_events  <= n_events + 1;
            last_code <= key_code;
        end
        if (!reset && key_overrun) n_overrun <= n_overrun + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_1000HZ);
    endtask

    task automatic align();
        while (cyc % 12 != 0) @(negedge clk_1000HZ);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic release_all();
        pressed = '0;
        align();
        step(60);
    endtask

    initial begin
        // reset state
        step(3);
        chk("rst_row", row, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_held", key_held, 0);
        chk("rst_overrun", key_overrun, 0);
        reset = 1'b0;
        step(2);
        chk("row_cyc2", row, 4'b1110);
        step(1);
        chk("row_cyc3", row, 4'b1101);

        // key 6, single event, hold, release, press again
        align();
        pressed = 16'(1 << 6);
        step(47);
        chk("k6_valid_early", key_valid, 0);
        step(1);
        chk("k6_valid", key_valid, 1);
        chk("k6_code", key_code, 6);
        chk("k6_held", key_held, 1);
        step(1);
        chk("k6_valid_1cyc", key_valid, 0);
        step(36);
        chk("k6_no_repeat", n_events, 1);
        chk("k6_still_held", key_held, 1);
        align();
        pressed = '0;
        step(47);
        chk("k6_rel_held", key_held, 1);
        step(1);
        chk("k6_rel_idle", key_held, 0);
        align();
        pressed = 16'(1 << 6);
        step(49);
        chk("k6_second_cnt", n_events, 2);
        chk("k6_second_code", last_code, 6);
        release_all();

        // key 11 bouncing: on, off, then stable
        align();
        pressed = 16'(1 << 11);
        step(12);
        pressed = '0;
        step(12);
        pressed = 16'(1 << 11);
        step(47);
        chk("k11_valid_early", key_valid, 0);
        step(1);
        chk("k11_valid", key_valid, 1);
        chk("k11_code", key_code, 11);
        release_all();
        chk("k11_one_event", n_events, 3);

        // keys 0 and 5 together are ghosting-guarded
        align();
        pressed = 16'h0021;
        step(72);
        chk("multi_no_event", n_events, 3);
        chk("multi_valid", key_valid, 0);
        chk("multi_held", key_held, 0);
        pressed = 16'(1 << 5);
        step(48);
        chk("k5_valid", key_valid, 1);
        chk("k5_code", key_code, 5);
        release_all();
        chk("k5_event_cnt", n_events, 4);

        // back-pressure: key 9 pending, key 3 overruns
        key_ready = 1'b0;
        align();
        pressed = 16'(1 << 9);
        step(48);
        chk("k9_valid", key_valid, 1);
        chk("k9_code", key_code, 9);
        chk("k9_held", key_held, 1);
        release_all();
        chk("k9_rel_held", key_held, 0);
        chk("k9_pending", key_valid, 1);
        align();
        pressed = 16'(1 << 3);
        step(47);
        chk("ovr_early", key_overrun, 0);
        step(1);
        chk("ovr_pulse", key_overrun, 1);
        chk("ovr_code_kept", key_code, 9);
        chk("ovr_valid_kept", key_valid, 1);
        step(1);
        chk("ovr_one_cycle", key_overrun, 0);
        chk("ovr_count", n_overrun, 1);
        key_ready = 1'b1;
        chk("accept_pre", key_valid, 1);
        step(1);
        chk("accept_drop", key_valid, 0);
        chk("accept_code", last_code, 9);
        chk("accept_cnt", n_events, 5);
        release_all();

        // reset mid-debounce with key 4 held
        align();
        pressed = 16'(1 << 4);
        step(30);
        reset = 1'b1;
        step(2);
        chk("midrst_row", row, 4'b1110);
        chk("midrst_valid", key_valid, 0);
        chk("midrst_held", key_held, 0);
        chk("midrst_no_event", n_events, 5);
        reset = 1'b0;
        step(47);
        chk("k4_valid_early", key_valid, 0);
        step(1);
        chk("k4_valid", key_valid, 1);
        chk("k4_code", key_code, 4);
        step(1);
        chk("k4_event_cnt", n_events, 6);
        chk("k4_no_overrun", n_overrun, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
